// File: rtl/sum_req_pkg.sv
// Shared types and default sizes for the sum-unit requester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_req_pkg;

  localparam int W_DEF       = 10;  // operand/result width
  localparam int TIMEOUT_DEF = 4;   // WAIT edges without valid before timeout
  localparam int CNT_W_DEF   = 16;  // completed-transaction counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_req_out_slot.sv
// Single-entry result register with valid/ready handoff and handoff counter.
// Latency: load visible on res_* the cycle after the load edge.
// Backpressure: holds the result while res_ready is low; never overwritten.
// Ports: load/load_sum/load_err write the slot; res_valid/res_ready handshake
//        with the consumer; txn_cnt counts handoffs and wraps.
module sum_req_out_slot #(
  parameter int W     = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     load_sum,
  input  logic             load_err,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [W-1:0]     res_sum,
  output logic             res_err,
  output logic [CNT_W-1:0] txn_cnt
);

  logic handoff;
  assign handoff = res_valid && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_err   <= 1'b0;
      txn_cnt   <= '0;
    end else begin
      // The requester only loads after accepting a new pair, which itself
      // needs an empty or draining slot, so a load never clobbers a result.
      if (load) begin
        res_valid <= 1'b1;
        res_sum   <= load_sum;
        res_err   <= load_err;
      end else if (handoff) begin
        res_valid <= 1'b0;
      end
      if (handoff) begin
        txn_cnt <= txn_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_requester.sv
// Issues operand pairs to a registered sum unit and returns result or timeout.
// Latency: accept to res_valid 2 cycles; issue interval 3 cycles.
// Backpressure: in_ready drops while busy or while an untaken result is held.
// Ports: in_* upstream ready/valid operands; start/a/b/y/valid to the sum unit;
//        res_* result port; err_spurious sticky stray-valid flag; txn_cnt.
module sum_requester
  import sum_req_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             start,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     y,
  input  logic             valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_sum,
  output logic             res_err,
  output logic             err_spurious,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  logic [W-1:0]    a_nxt, b_nxt;
  logic            start_nxt, spur_nxt;
  logic            load, load_err;
  logic [W-1:0]    load_sum;

  assign in_ready = (state == IDLE) && (!res_valid || res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wcnt         <= '0;
      start        <= 1'b0;
      a            <= '0;
      b            <= '0;
      err_spurious <= 1'b0;
    end else begin
      state        <= state_nxt;
      wcnt         <= wcnt_nxt;
      start        <= start_nxt;
      a            <= a_nxt;
      b            <= b_nxt;
      err_spurious <= spur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    start_nxt = 1'b0;
    a_nxt     = a;
    b_nxt     = b;
    spur_nxt  = err_spurious;
    load      = 1'b0;
    load_sum  = '0;
    load_err  = 1'b0;
    case (state)
      IDLE: begin
        // A valid here is either unsolicited or arrived after a timeout.
        if (valid) spur_nxt = 1'b1;
        if (in_valid && in_ready) begin
          a_nxt     = in_a;
          b_nxt     = in_b;
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (valid) spur_nxt = 1'b1;
        wcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (valid) begin
          load      = 1'b1;
          load_sum  = y;
          state_nxt = IDLE;
        end else if (wcnt == WC_LAST) begin
          // TIMEOUT consecutive WAIT edges without a response.
          load      = 1'b1;
          load_err  = 1'b1;
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sum_req_out_slot #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_sum  (load_sum),
    .load_err  (load_err),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_err   (res_err),
    .txn_cnt   (txn_cnt)
  );

endmodule

// File: tb/tb_sum_requester.sv
// Bench for sum_requester with a registered sum-unit responder and scoreboard.
// Latency: n/a.
// Backpressure: res_ready is driven by the sequences below.
module tb_sum_requester;

  localparam int W       = 10;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [W-1:0]     in_a, in_b;
  logic             start;
  logic [W-1:0]     a, b, y;
  logic             valid;
  logic             res_valid, res_ready;
  logic [W-1:0]     res_sum;
  logic             res_err, err_spurious;
  logic [CNT_W-1:0] txn_cnt;

  always #5 clk = ~clk;

  sum_requester #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .start        (start),
    .a            (a),
    .b            (b),
    .y            (y),
    .valid        (valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sum      (res_sum),
    .res_err      (res_err),
    .err_spurious (err_spurious),
    .txn_cnt      (txn_cnt)
  );

  // Registered sum unit model; resp_en=0 makes it silent.
  logic         resp_en, unit_valid, spur_valid;
  logic [W-1:0] unit_y;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_valid <= 1'b0;
      unit_y     <= '0;
    end else begin
      unit_valid <= start && resp_en;
      unit_y     <= a + b;
    end
  end
  assign valid = unit_valid | spur_valid;
  assign y     = unit_y;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (start) start_cnt <= start_cnt + 1;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         err;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every handoff is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got sum %0d err %0d, expected none", res_sum, res_err);
      end else begin
        mon_e = q.pop_front();
        chk("sb_res_sum", 32'(res_sum), 32'(mon_e.sum));
        chk("sb_res_err", 32'(res_err), 32'(mon_e.err));
      end
    end
  end

  // Offer a pair; push its expected result just before the accepting edge.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] esum, input logic eerr, input bit hold);
    int k;
    exp_t e;
    in_a = va;
    in_b = vb;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    e.sum = esum;
    e.err = eerr;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 32'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         resp;
    logic [W-1:0] esum;
    logic         eerr;
  } vec_t;
  vec_t tv[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, s0;
    int acc[10];
    logic [W-1:0] ra, rb, rs;

    tv[0] = '{va: 3,    vb: 5,   resp: 1, esum: 8,    eerr: 0};
    tv[1] = '{va: 1023, vb: 1,   resp: 1, esum: 0,    eerr: 0};
    tv[2] = '{va: 512,  vb: 511, resp: 1, esum: 1023, eerr: 0};
    tv[3] = '{va: 600,  vb: 600, resp: 1, esum: 176,  eerr: 0};
    tv[4] = '{va: 77,   vb: 88,  resp: 0, esum: 0,    eerr: 1};
    tv[5] = '{va: 0,    vb: 0,   resp: 1, esum: 0,    eerr: 0};

    in_valid = 0; in_a = 0; in_b = 0; res_ready = 1; resp_en = 1; spur_valid = 0;
    do_reset();

    // Reset state
    chk("rst_start", 32'(start), 0);
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_err_spurious", 32'(err_spurious), 0);
    chk("rst_txn_cnt", 32'(txn_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // First transaction with cycle-accurate latency checks
    s0 = start_cnt;
    send(3, 5, 8, 0, 0);
    chk("t1_start_hi", 32'(start), 1);
    chk("t1_a", 32'(a), 3);
    chk("t1_b", 32'(b), 5);
    @(posedge clk); @(negedge clk);
    chk("t1_start_lo", 32'(start), 0);
    chk("t1_res_valid_e1", 32'(res_valid), 0);
    @(posedge clk); @(negedge clk);
    chk("t1_res_valid_e2", 32'(res_valid), 1);
    chk("t1_res_sum", 32'(res_sum), 8);
    @(posedge clk); @(negedge clk);
    chk("t1_txn_cnt", 32'(txn_cnt), 1);
    chk("t1_one_start", 32'(start_cnt - s0), 1);
    chk("t1_a_held", 32'(a), 3);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      resp_en = tv[i].resp;
      send(tv[i].va, tv[i].vb, tv[i].esum, tv[i].eerr, 0);
      wait_empty();
      chk("tv_err_spurious", 32'(err_spurious), 0);
    end
    chk("tv_txn_cnt", 32'(txn_cnt), 7);

    // Timeout with result held, then a late valid
    resp_en = 0;
    res_ready = 0;
    send(7, 9, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 4) chk("to_res_valid_e4", 32'(res_valid), 0);
      if (k == 5) begin
        chk("to_res_valid_e5", 32'(res_valid), 1);
        chk("to_res_err", 32'(res_err), 1);
        chk("to_res_sum", 32'(res_sum), 0);
        chk("to_no_spur_yet", 32'(err_spurious), 0);
      end
    end
    @(posedge clk); #1 spur_valid = 1;
    @(posedge clk); #1 spur_valid = 0;
    @(negedge clk);
    chk("late_err_spurious", 32'(err_spurious), 1);
    chk("late_res_valid", 32'(res_valid), 1);
    chk("late_res_err", 32'(res_err), 1);
    chk("late_res_sum", 32'(res_sum), 0);
    res_ready = 1;
    wait_empty();
    chk("late_spur_sticky", 32'(err_spurious), 1);

    // Back-pressure
    resp_en = 1;
    res_ready = 0;
    send(10, 20, 30, 0, 0);
    bad = 0;
    while (!res_valid && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    chk("bp_res_valid", 32'(res_valid), 1);
    in_a = 40; in_b = 10; in_valid = 1;
    s0 = start_cnt;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    chk("bp_in_ready_low", 32'(bad), 0);
    chk("bp_no_start", 32'(start_cnt - s0), 0);
    @(posedge clk); #1;
    res_ready = 1;
    mon_e.sum = 50; mon_e.err = 0;
    q.push_back(mon_e);
    @(negedge clk);
    chk("bp_in_ready_release", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("bp_next_start", 32'(start), 1);
    chk("bp_next_a", 32'(a), 40);
    in_valid = 0;
    wait_empty();

    // Reset during WAIT
    resp_en = 0;
    send(1, 2, 3, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("mid_rst_start", 32'(start), 0);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_txn_cnt", 32'(txn_cnt), 0);
    chk("mid_rst_err_spurious", 32'(err_spurious), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    resp_en = 1;
    send(40, 2, 42, 0, 0);
    wait_empty();
    chk("post_rst_txn_cnt", 32'(txn_cnt), 1);

    // Back-to-back random pairs
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 1023));
      rb = W'($urandom_range(0, 1023));
      rs = ra + rb;
      send(ra, rb, rs, 0, 1);
      acc[i] = cyc;
    end
    in_valid = 0;
    for (int i = 1; i < 10; i++) chk("b2b_interval", 32'(acc[i] - acc[i-1]), 3);
    wait_empty();
    chk("b2b_txn_cnt", 32'(txn_cnt), 10);
    chk("b2b_starts", 32'(start_cnt - s0), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
